// File: rtl/joypad_pkg.sv
// Shared definitions for the joypad reader: FSM states, button bit positions
// in the published vector, and field positions of the raw pad lines.
package joypad_pkg;

    localparam int unsigned PAD_W = 6;
    localparam int unsigned BTN_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEL_HI = 2'd1,
        SEL_LO = 2'd2,
        UPDATE = 2'd3
    } state_t;

    // Bit positions in the buttons vector {start, a, c, b, right, left, down, up}
    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_B     = 4;
    localparam int unsigned BTN_C     = 5;
    localparam int unsigned BTN_A     = 6;
    localparam int unsigned BTN_START = 7;

    // Bit positions in pad_in {up, down, left, right, a_b, c_s}
    localparam int unsigned PAD_C_S   = 0;
    localparam int unsigned PAD_A_B   = 1;
    localparam int unsigned PAD_RIGHT = 2;
    localparam int unsigned PAD_LEFT  = 3;
    localparam int unsigned PAD_DOWN  = 4;
    localparam int unsigned PAD_UP    = 5;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Ports: i_clk clock, i_rst async active-high reset (clears to 0),
//        i_d asynchronous input, o_q synchronized output.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/joypad_reader.sv
// Scans a 3-button joypad through its select line once per SCAN_PERIOD and
// publishes a (optionally debounced) button vector.
// Ports: clock, reset (async active-high); pad_in raw active-high pad lines;
//        pad_sel pad select pin; buttons {start,a,c,b,right,left,down,up};
//        pad_present pad detected on last scan; scan_valid one-cycle pulse
//        per completed scan; buttons_changed pulse when buttons moved.
module joypad_reader
    import joypad_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD   = 833333,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned DEBOUNCE      = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [PAD_W-1:0] pad_in,
    output logic             pad_sel,
    output logic [BTN_W-1:0] buttons,
    output logic             pad_present,
    output logic             scan_valid,
    output logic             buttons_changed
);

    localparam int unsigned PW = $clog2(SCAN_PERIOD);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES);

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_per;
    logic [SW-1:0]      r_settle;
    logic               w_per_last;
    logic               w_settle_last;
    logic [PAD_W-1:0]   w_pad_sync;

    // Phase captures
    logic               r_up, r_down, r_left, r_right, r_b, r_c;
    logic               r_a, r_start, r_present_ph;

    logic [BTN_W-1:0]   r_stored;
    logic [BTN_W-1:0]   r_buttons;
    logic               r_present;
    logic               r_scan_valid;
    logic               r_changed;
    logic               r_pad_sel;
    logic [BTN_W-1:0]   w_raw;
    logic [BTN_W-1:0]   w_new_buttons;

    sync_2ff #(.WIDTH(PAD_W)) u_sync (
        .i_clk (clock),
        .i_rst (reset),
        .i_d   (pad_in),
        .o_q   (w_pad_sync)
    );

    assign w_per_last    = (r_per == PW'(SCAN_PERIOD - 1));
    assign w_settle_last = (r_settle == SW'(SETTLE_CYCLES - 1));

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state, raw scan assembly and debounce decision
    always_comb begin
        w_next        = r_state;
        w_raw         = '0;
        w_new_buttons = r_buttons;
        case (r_state)
            IDLE:    if (w_per_last)    w_next = SEL_HI;
            SEL_HI:  if (w_settle_last) w_next = SEL_LO;
            SEL_LO:  if (w_settle_last) w_next = UPDATE;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (r_present_ph) begin
            w_raw[BTN_UP]    = r_up;
            w_raw[BTN_DOWN]  = r_down;
            w_raw[BTN_LEFT]  = r_left;
            w_raw[BTN_RIGHT] = r_right;
            w_raw[BTN_B]     = r_b;
            w_raw[BTN_C]     = r_c;
            w_raw[BTN_A]     = r_a;
            w_raw[BTN_START] = r_start;
        end
        if ((DEBOUNCE == 0) || (w_raw == r_stored)) w_new_buttons = w_raw;
    end

    // Free-running period counter and per-phase settle counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_per    <= '0;
            r_settle <= '0;
        end else begin
            r_per <= w_per_last ? '0 : r_per + PW'(1);
            if (((r_state == SEL_HI) || (r_state == SEL_LO)) && !w_settle_last)
                r_settle <= r_settle + SW'(1);
            else
                r_settle <= '0;
        end
    end

    // Phase captures, published outputs and pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_up         <= 1'b0;
            r_down       <= 1'b0;
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_b          <= 1'b0;
            r_c          <= 1'b0;
            r_a          <= 1'b0;
            r_start      <= 1'b0;
            r_present_ph <= 1'b0;
            r_stored     <= '0;
            r_buttons    <= '0;
            r_present    <= 1'b0;
            r_scan_valid <= 1'b0;
            r_changed    <= 1'b0;
            r_pad_sel    <= 1'b1;
        end else begin
            r_scan_valid <= 1'b0;
            r_changed    <= 1'b0;
            // Registered from next state so pad_sel is low exactly in SEL_LO
            r_pad_sel    <= (w_next != SEL_LO);
            if ((r_state == SEL_HI) && w_settle_last) begin
                r_up    <= w_pad_sync[PAD_UP];
                r_down  <= w_pad_sync[PAD_DOWN];
                r_left  <= w_pad_sync[PAD_LEFT];
                r_right <= w_pad_sync[PAD_RIGHT];
                r_b     <= w_pad_sync[PAD_A_B];
                r_c     <= w_pad_sync[PAD_C_S];
            end
            if ((r_state == SEL_LO) && w_settle_last) begin
                r_a          <= w_pad_sync[PAD_A_B];
                r_start      <= w_pad_sync[PAD_C_S];
                // A 3-button pad reports left and right both low-active here
                r_present_ph <= w_pad_sync[PAD_LEFT] & w_pad_sync[PAD_RIGHT];
            end
            if (r_state == UPDATE) begin
                r_present    <= r_present_ph;
                r_buttons    <= w_new_buttons;
                r_stored     <= w_raw;
                r_scan_valid <= 1'b1;
                r_changed    <= (w_new_buttons != r_buttons);
            end
        end
    end

    assign pad_sel         = r_pad_sel;
    assign buttons         = r_buttons;
    assign pad_present     = r_present;
    assign scan_valid      = r_scan_valid;
    assign buttons_changed = r_changed;

endmodule

// File: tb/tb_joypad_reader.sv
module tb_joypad_reader;

    localparam int unsigned SP = 32;
    localparam int unsigned ST = 4;

    logic       clock;
    logic       reset;
    logic [5:0] pad_hi, pad_lo;

    logic [5:0] pad_in_d, pad_in_n;
    logic       sel_d, sel_n;
    logic [7:0] btn_d, btn_n;
    logic       pres_d, pres_n, sv_d, sv_n, chg_d, chg_n;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] b_d;
        logic       c_d;
        logic [7:0] b_n;
        logic       c_n;
        logic       p;
    } exp_t;

    exp_t q[$];

    // Reference model state: last raw scan and published buttons per variant
    logic [7:0] m_prev, m_btn, m_btn_n;

    joypad_reader #(.SCAN_PERIOD(SP), .SETTLE_CYCLES(ST), .DEBOUNCE(1)) dut (
        .clock(clock), .reset(reset), .pad_in(pad_in_d), .pad_sel(sel_d),
        .buttons(btn_d), .pad_present(pres_d), .scan_valid(sv_d),
        .buttons_changed(chg_d)
    );

    joypad_reader #(.SCAN_PERIOD(SP), .SETTLE_CYCLES(ST), .DEBOUNCE(0)) dut_nd (
        .clock(clock), .reset(reset), .pad_in(pad_in_n), .pad_sel(sel_n),
        .buttons(btn_n), .pad_present(pres_n), .scan_valid(sv_n),
        .buttons_changed(chg_n)
    );

    // The pad answers its select line immediately
    assign pad_in_d = sel_d ? pad_hi : pad_lo;
    assign pad_in_n = sel_n ? pad_hi : pad_lo;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode one scan from the pad's two select-phase line patterns
    function automatic logic [7:0] decode(input logic [5:0] hi, input logic [5:0] lo);
        logic present;
        present = lo[3] & lo[2];
        if (!present) return 8'h00;
        return {lo[0], lo[1], hi[0], hi[1], hi[2], hi[3], hi[4], hi[5]};
    endfunction

    task automatic model_reset();
        m_prev  = 8'h00;
        m_btn   = 8'h00;
        m_btn_n = 8'h00;
        q.delete();
    endtask

    task automatic push_expect(input logic [5:0] hi, input logic [5:0] lo);
        exp_t e;
        logic [7:0] raw, nb;
        raw   = decode(hi, lo);
        nb    = (raw == m_prev) ? raw : m_btn;
        e.p   = lo[3] & lo[2];
        e.b_d = nb;
        e.c_d = (nb != m_btn);
        e.b_n = raw;
        e.c_n = (raw != m_btn_n);
        m_btn   = nb;
        m_prev  = raw;
        m_btn_n = raw;
        q.push_back(e);
    endtask

    // Counts posedges until scan_valid is seen; n = -1 on timeout
    task automatic wait_scan(output int n);
        n = -1;
        for (int i = 1; i <= 3 * SP; i++) begin
            @(posedge clock);
            #1;
            if (sv_d) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            errors++;
            $display("FAIL scan_timeout no scan_valid within %0d cycles", 3 * SP);
        end
    endtask

    task automatic run_scan(input logic [5:0] hi, input logic [5:0] lo);
        int n;
        pad_hi = hi;
        pad_lo = lo;
        push_expect(hi, lo);
        wait_scan(n);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pad_sel"}, 32'(sel_d), 32'd1);
        chk({tag, "_buttons"}, 32'(btn_d), 32'd0);
        chk({tag, "_present"}, 32'(pres_d), 32'd0);
        chk({tag, "_scan_valid"}, 32'(sv_d), 32'd0);
        chk({tag, "_changed"}, 32'(chg_d), 32'd0);
        chk({tag, "_nd_buttons"}, 32'(btn_n), 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (!reset) begin
            if (sv_d) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_scan_valid actual=1 expected=0 at %0t", $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("buttons",        32'(btn_d),  32'(e.b_d));
                    chk("changed",        32'(chg_d),  32'(e.c_d));
                    chk("pad_present",    32'(pres_d), 32'(e.p));
                    chk("nd_scan_valid",  32'(sv_n),   32'd1);
                    chk("nd_buttons",     32'(btn_n),  32'(e.b_n));
                    chk("nd_changed",     32'(chg_n),  32'(e.c_n));
                    chk("nd_pad_present", 32'(pres_n), 32'(e.p));
                end
            end else if (chg_d || sv_n) begin
                errors++;
                $display("FAIL stray_pulse changed=%0b nd_valid=%0b expected=0 at %0t",
                         chg_d, sv_n, $time);
            end
        end
    end

    // Select-low width and scan spacing monitor
    int  low_run = 0;
    int  gap = 0;
    logic have_prev = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            low_run   = 0;
            gap       = 0;
            have_prev = 1'b0;
        end else begin
            if (!sel_d) low_run++;
            else if (low_run != 0) begin
                chk("sel_low_len", 32'(low_run), 32'(ST));
                low_run = 0;
            end
            gap++;
            if (sv_d) begin
                if (have_prev) chk("scan_period", 32'(gap), 32'(SP));
                have_prev = 1'b1;
                gap       = 0;
            end
        end
    end

    initial begin
        int n;
        int first_low;
        logic [5:0] hi, lo;
        reset  = 1'b1;
        pad_hi = 6'b000000;
        pad_lo = 6'b000000;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("por");
        @(negedge clock);
        reset = 1'b0;

        // Pad absent
        for (int i = 0; i < 3; i++) run_scan(6'b000000, 6'b000000);

        // Up+B held
        for (int i = 0; i < 4; i++) run_scan(6'b100010, 6'b001100);

        // Single-scan B release is filtered, double release is accepted
        run_scan(6'b100000, 6'b001100);
        run_scan(6'b100010, 6'b001100);
        run_scan(6'b100010, 6'b001100);
        run_scan(6'b100000, 6'b001100);
        run_scan(6'b100000, 6'b001100);

        // Start+A (the non-debounced instance shows C0 on its first scan)
        run_scan(6'b000000, 6'b001111);
        run_scan(6'b000000, 6'b001111);

        // Randomised scans, often repeating to let debounce settle
        hi = 6'b0;
        lo = 6'b0;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                hi = 6'($urandom);
                lo = 6'($urandom);
                if ($urandom_range(0, 3) != 0) lo[3:2] = 2'b11;
            end
            run_scan(hi, lo);
        end

        // Reset on the second SEL_LO cycle of a scan
        pad_hi = 6'b100010;
        pad_lo = 6'b001100;
        n = -1;
        for (int i = 0; i < 3 * SP; i++) begin
            @(posedge clock);
            #1;
            if (!sel_d) begin
                n = i;
                break;
            end
        end
        chk("reach_sel_lo", 32'(n >= 0), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check_reset_values("mid");
        chk("mid_nd_pad_sel", 32'(sel_n), 32'd1);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        push_expect(6'b100010, 6'b001100);
        first_low = -1;
        n = -1;
        for (int i = 1; i <= 3 * SP; i++) begin
            @(posedge clock);
            #1;
            if (!sel_d && first_low < 0) first_low = i;
            if (sv_d) begin
                n = i;
                break;
            end
        end
        chk("restart_sel_low", 32'(first_low), 32'(SP + ST));
        chk("restart_scan_valid", 32'(n), 32'(SP + 2 * ST + 1));

        run_scan(6'b100010, 6'b001100);
        run_scan(6'b100010, 6'b001100);

        repeat (4) @(posedge clock);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
